vga_text: RTL and testbench

Text-mode pixel generator that sits directly upstream of the VGA timing generator and supplies its `pixel` input. It renders a 40×30 character screen with 8×8 glyphs, each glyph pixel doubled horizontally, into the 640×480 active area; the timing generator already doubles lines vertically. Character codes live in an internal 2048×8 RAM with a write port for the CPU side. Glyph bitmaps come from an external synchronous font ROM.

---
 rtl/vga_text.sv | 171 +++++++++++++++++
 tb/tb_vga_text.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text.sv
// Text-mode pixel source: 40x30 characters of 8x8 glyphs, each glyph pixel doubled horizontally.
// Character codes are kept in an internal 2048x8 RAM; glyph rows come from an external font ROM.
module vga_text #(
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        newline,
    input  logic        advance,
    input  logic [7:0]  line,
    output logic [11:0] pixel,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RDCHAR = 2'd1,
        S_RDFONT = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;

    logic [7:0]  char_mem [0:2047];
    logic [7:0]  ram_q_r;

    logic [7:0]  shift_r;
    logic [7:0]  hold_r;
    logic        hold_v_r;
    logic [5:0]  dcol_r;
    logic [2:0]  bitc_r;
    logic        sub_r;
    logic        first_r;
    logic [5:0]  fcol_r;
    logic [10:0] font_addr_r;

    logic [10:0] row_s;
    logic [10:0] rd_addr_s;
    logic        rd_en_s;
    logic        font_ld_s;
    logic        glyph_ld_s;

    assign row_s     = {6'd0, line[7:3]};
    assign rd_addr_s = (row_s << 5) + (row_s << 3) + {5'd0, fcol_r};

    // Character RAM: CPU write port plus synchronous read port (old data on collision)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            char_mem[wr_addr] <= wr_data;
        end
        if (rd_en_s) begin
            ram_q_r <= char_mem[rd_addr_s];
        end
    end

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Fetch FSM next-state logic; a newline restarts the fetch and aborts any in flight
    always_comb begin
        state_nx_s = state_r;
        if (newline) begin
            state_nx_s = S_RDCHAR;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!hold_v_r && (fcol_r < 6'd40)) begin
                        state_nx_s = S_RDCHAR;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_RDCHAR: state_nx_s = S_RDFONT;
                S_RDFONT: state_nx_s = S_WAIT;
                S_WAIT:   state_nx_s = S_IDLE;
                default:  state_nx_s = S_IDLE;
            endcase
        end
    end

    // Fetch FSM output decode
    always_comb begin
        rd_en_s    = 1'b0;
        font_ld_s  = 1'b0;
        glyph_ld_s = 1'b0;
        if (newline) begin
            rd_en_s = 1'b0;
        end else begin
            case (state_r)
                S_RDCHAR: rd_en_s    = 1'b1;
                S_RDFONT: font_ld_s  = 1'b1;
                S_WAIT:   glyph_ld_s = 1'b1;
                default:  rd_en_s    = 1'b0;
            endcase
        end
    end

    // Display datapath: pixel stepping, glyph refill and fetch column bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r     <= 8'd0;
            hold_r      <= 8'd0;
            hold_v_r    <= 1'b0;
            dcol_r      <= 6'd0;
            bitc_r      <= 3'd0;
            sub_r       <= 1'b0;
            first_r     <= 1'b0;
            fcol_r      <= 6'd40;
            font_addr_r <= 11'd0;
        end else if (newline) begin
            shift_r  <= 8'd0;
            hold_v_r <= 1'b0;
            dcol_r   <= 6'd0;
            bitc_r   <= 3'd0;
            sub_r    <= 1'b0;
            first_r  <= 1'b1;
            fcol_r   <= 6'd0;
        end else begin
            if (advance) begin
                sub_r <= ~sub_r;
                if (sub_r) begin
                    bitc_r <= bitc_r + 3'd1;
                    if (bitc_r == 3'd7) begin
                        // Past the last column the line is padded with background
                        if (dcol_r >= 6'd39) begin
                            shift_r <= 8'd0;
                        end else begin
                            shift_r <= hold_v_r ? hold_r : 8'd0;
                        end
                        hold_v_r <= 1'b0;
                        if (dcol_r < 6'd40) begin
                            dcol_r <= dcol_r + 6'd1;
                        end
                    end else begin
                        shift_r <= {shift_r[6:0], 1'b0};
                    end
                end
            end
            if (font_ld_s) begin
                font_addr_r <= {ram_q_r, line[2:0]};
            end
            // A completed fetch wins over a boundary that just emptied hold
            if (glyph_ld_s) begin
                if (first_r) begin
                    shift_r <= font_data;
                    first_r <= 1'b0;
                end else begin
                    hold_r   <= font_data;
                    hold_v_r <= 1'b1;
                end
                fcol_r <= fcol_r + 6'd1;
            end
        end
    end

    assign font_addr = font_addr_r;
    assign pixel     = shift_r[7] ? FG_COLOR : BG_COLOR;

endmodule

// File: tb/tb_vga_text.sv
// Bench for vga_text: a line-level model predicts every pixel from RAM contents, font and
// advance count; directed scenarios add hand-computed expectations for key points.
module tb_vga_text;

    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        newline = 1'b0;
    logic        advance = 1'b0;
    logic [7:0]  line = 8'd0;
    logic [11:0] pixel;
    logic        wr_en = 1'b0;
    logic [10:0] wr_addr = 11'd0;
    logic [7:0]  wr_data = 8'd0;
    logic [10:0] font_addr;
    logic [7:0]  font_data;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [7:0] m_mem [0:2047];
    logic [7:0] m_codes [0:39];
    logic [2:0] m_gr = 3'd0;
    logic       m_started = 1'b0;
    int         m_since = 0;
    int         m_k = 0;

    vga_text #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clk       (clk),
        .reset     (reset),
        .newline   (newline),
        .advance   (advance),
        .line      (line),
        .pixel     (pixel),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .font_addr (font_addr),
        .font_data (font_data)
    );

    always #20 clk = ~clk;

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        logic [7:0] v;
        if (a == 11'h208) v = 8'hA5;
        else              v = (a[10:3] ^ {a[2:0], a[2:0], a[1:0]}) + 8'h5B;
        return v;
    endfunction

    // Font ROM: data for the address the DUT has registered
    assign font_data = font_fn(font_addr);

    function automatic logic [11:0] model_pixel();
        int c;
        int b;
        logic [7:0] g;
        if (!m_started || m_since < 3) return BG;
        c = m_k / 16;
        if (c >= 40) return BG;
        g = font_fn({m_codes[c], m_gr});
        b = 7 - (m_k % 16) / 2;
        return g[b] ? FG : BG;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update at each clock edge from the inputs the DUT samples
    initial begin
        for (int i = 0; i < 2048; i++) m_mem[i] = 8'd0;
        for (int i = 0; i < 40; i++) m_codes[i] = 8'd0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_started = 1'b0;
            end else if (newline) begin
                m_started = 1'b1;
                m_since = 0;
                m_k = 0;
                m_gr = line[2:0];
                for (int c = 0; c < 40; c++) m_codes[c] = m_mem[int'(line[7:3]) * 40 + c];
            end else begin
                if (m_since < 1000) m_since++;
                if (advance) m_k++;
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
    end

    // Per-cycle pixel comparison against the model
    always @(negedge clk) begin
        if (chk_en) check("pixel_model", 32'(pixel), 32'(model_pixel()));
    end

    task automatic run_line(input logic [7:0] ln, input int nadv, output logic [10:0] fa);
        line = ln;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        tick();
        tick();
        fa = font_addr;
        repeat (7) tick();
        advance = 1'b1;
        repeat (nadv) tick();
        advance = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic [10:0] fa;
        logic [7:0]  pat;

        tick();
        chk_en = 1'b1;
        tick();
        check("reset_pixel", 32'(pixel), 32'(12'h000));
        check("reset_font_addr", 32'(font_addr), 32'(11'd0));
        reset = 1'b0;

        // No newline yet: background throughout a full line of advances
        advance = 1'b1;
        repeat (640) tick();
        advance = 1'b0;
        check("no_newline_bg", 32'(pixel), 32'(BG));

        // Fill the character RAM; one write beyond the visible area
        wr_en = 1'b1;
        for (int a = 0; a < 1200; a++) begin
            wr_addr = 11'(a);
            wr_data = (a == 0) ? 8'h41 : 8'(a * 7 + 3);
            tick();
        end
        wr_addr = 11'd1500;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        tick();

        // Single glyph followed by the rest of a full line
        line = 8'd0;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        tick();
        tick();
        check("glyph_font_addr", 32'(font_addr), 32'(11'h208));
        repeat (7) tick();
        pat = 8'hA5;
        for (int j = 0; j < 16; j++) begin
            advance = 1'b1;
            check("glyph_pixel", 32'(pixel), 32'(pat[7 - j / 2] ? FG : BG));
            tick();
        end
        repeat (624) tick();
        advance = 1'b0;
        tick();
        check("line_end_bg", 32'(pixel), 32'(BG));
        check("last_fetch_row0", 32'(font_addr), 32'({8'h14, 3'd0}));
        advance = 1'b1;
        repeat (20) tick();
        advance = 1'b0;
        check("no_fetch_after_40", 32'(font_addr), 32'({8'h14, 3'd0}));

        // Addressing: line 9 -> row 1 glyph row 1; line 239 -> row 29 glyph row 7
        run_line(8'd9, 640, fa);
        check("line9_first_fetch", 32'(fa), 32'({8'h1B, 3'd1}));
        run_line(8'd239, 640, fa);
        check("line239_first_fetch", 32'(fa), 32'({8'hBB, 3'd7}));
        check("line239_last_fetch", 32'(font_addr), 32'({8'hCC, 3'd7}));

        // Newline arriving together with advance 300
        line = 8'd0;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        repeat (8) tick();
        advance = 1'b1;
        repeat (299) tick();
        newline = 1'b1;
        tick();
        newline = 1'b0;
        advance = 1'b0;
        check("midline_cleared", 32'(pixel), 32'(BG));
        tick();
        tick();
        check("midline_not_yet", 32'(pixel), 32'(BG));
        tick();
        check("midline_col0_loaded", 32'(pixel), 32'(FG));
        repeat (6) tick();
        advance = 1'b1;
        repeat (640) tick();
        advance = 1'b0;
        repeat (4) tick();

        // Write to address 0 in the cycle column 0 is read: old code is rendered
        line = 8'd0;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        wr_en = 1'b1;
        wr_addr = 11'd0;
        wr_data = 8'h42;
        tick();
        wr_en = 1'b0;
        tick();
        check("collision_old_code", 32'(font_addr), 32'(11'h208));
        repeat (7) tick();
        advance = 1'b1;
        repeat (64) tick();
        advance = 1'b0;
        repeat (4) tick();

        // Reset during advance 100, then a clean restart
        line = 8'd0;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        repeat (8) tick();
        advance = 1'b1;
        repeat (99) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        advance = 1'b0;
        check("reset_mid_pixel", 32'(pixel), 32'(BG));
        check("reset_mid_font_addr", 32'(font_addr), 32'(11'd0));
        advance = 1'b1;
        repeat (50) tick();
        advance = 1'b0;
        check("reset_mid_idle_bg", 32'(pixel), 32'(BG));
        run_line(8'd0, 640, fa);
        check("restart_new_code", 32'(fa), 32'(11'h210));

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
